// File: rtl/fmad_pkg.sv
// Shared definitions for the fmad result path: command codes, exception flag layout
// and the queued response entry.
package fmad_pkg;

    localparam logic [31:0] CMD_FMA    = 32'd1;
    localparam logic [31:0] CMD_DOT    = 32'd13;
    localparam int          RESP_TAG_W = 4;

    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } fflags_t;

    typedef struct packed {
        logic [31:0]           rslt;
        fflags_t               flag;
        logic [RESP_TAG_W-1:0] tag;
    } resp_entry_t;

    // Only scalar FMA produces a result; dot-accumulate updates fmad state only.
    function automatic logic is_queued_cmd(input logic [31:0] cmd);
        return cmd == CMD_FMA;
    endfunction

endpackage

// File: rtl/fmad_resp_fifo.sv
// Circular result buffer of DEPTH resp_entry_t slots; head is presented combinationally.
// Pointers wrap naturally because DEPTH is a power of two.
module fmad_resp_fifo
    import fmad_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  resp_entry_t              i_push_data,
    input  logic                     i_pop,
    output resp_entry_t              o_head,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PTR_W = $clog2(DEPTH);

    resp_entry_t       r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W:0]    r_count;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: storage is not reset; the count alone decides which slots hold live data.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(i_push && !i_pop && r_count == (PTR_W+1)'(DEPTH)));

    a_no_underflow: assert property (@(posedge clk) disable iff (reset)
        !(i_pop && r_count == '0));

endmodule

// File: rtl/fmad_resp_queue.sv
// Buffers fixed-latency fmad results behind a credit-gated issue port and a valid/ready output.
// Define FMAD_RESP_STICKY_EN to accrue popped exception flags into fflags.
module fmad_resp_queue
    import fmad_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int LAT   = 2,
    parameter int TAG_W = RESP_TAG_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req,
    input  logic [31:0]      req_command,
    input  logic [TAG_W-1:0] req_tag,
    output logic             req_ready,
    input  logic [31:0]      fmad_rslt,
    input  logic [4:0]       fmad_flag,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [31:0]      resp_rslt,
    output logic [4:0]       resp_flag,
    output logic [TAG_W-1:0] resp_tag,
    output logic [4:0]       fflags,
    input  logic             fflags_clr
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             w_take;
    logic             w_take_ok;
    logic             w_capture;
    logic             w_pop;
    logic [CNT_W-1:0] w_count;
    logic [CNT_W:0]   w_inflight;
    resp_entry_t      w_push_data;
    resp_entry_t      w_head;

    logic [LAT-1:0]   r_pipe_v;
    logic [TAG_W-1:0] r_pipe_tag [LAT];

    assign w_take    = req & is_queued_cmd(req_command);
    assign w_take_ok = w_take & req_ready;

    // Shadow of the fmad pipeline: one valid/tag pair per stage of fixed latency.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pipe_v <= '0;
        end else begin
            r_pipe_v[0] <= w_take_ok;
            for (int i = 1; i < LAT; i++) begin
                r_pipe_v[i] <= r_pipe_v[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        r_pipe_tag[0] <= req_tag;
        for (int i = 1; i < LAT; i++) begin
            r_pipe_tag[i] <= r_pipe_tag[i-1];
        end
    end

    assign w_capture   = r_pipe_v[LAT-1];
    assign w_push_data = '{rslt: fmad_rslt, flag: fflags_t'(fmad_flag), tag: r_pipe_tag[LAT-1]};

    fmad_resp_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_capture),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_count     (w_count)
    );

    // Every op in the pipe already owns a FIFO slot, so capture can never find the FIFO full.
    assign w_inflight = (CNT_W+1)'($countones(r_pipe_v)) + (CNT_W+1)'(w_count);
    assign resp_valid = (w_count != '0) & ~reset;
    assign w_pop      = resp_valid & resp_ready;
    assign req_ready  = reset | (w_inflight < (CNT_W+1)'(DEPTH)) | w_pop;

    assign resp_rslt = w_head.rslt;
    assign resp_flag = w_head.flag;
    assign resp_tag  = w_head.tag;

`ifdef FMAD_RESP_STICKY_EN
    fflags_t r_fflags;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fflags <= '0;
        end else if (fflags_clr) begin
            r_fflags <= w_pop ? w_head.flag : fflags_t'('0);
        end else if (w_pop) begin
            r_fflags <= r_fflags | w_head.flag;
        end
    end

    assign fflags = r_fflags;
`else
    logic w_unused_fflags_clr;

    assign w_unused_fflags_clr = fflags_clr;
    assign fflags              = '0;
`endif

    a_issue_protocol: assert property (@(posedge clk) disable iff (reset)
        !(w_take && !req_ready));

    a_capture_not_full: assert property (@(posedge clk) disable iff (reset)
        !(w_capture && !w_pop && w_count == CNT_W'(DEPTH)));

endmodule

// File: tb/tb_fmad_resp_queue.sv
// Randomized scoreboard bench for fmad_resp_queue; a queue of issued ops, each stamped with
// the cycle it must become visible, is the reference model. Honours FMAD_RESP_STICKY_EN.
module tb_fmad_resp_queue;
    import fmad_pkg::*;

    localparam int DEPTH = 4;
    localparam int LAT   = 2;
    localparam int TAG_W = 4;

    logic             clk         = 1'b0;
    logic             reset       = 1'b1;
    logic             req         = 1'b0;
    logic [31:0]      req_command = '0;
    logic [TAG_W-1:0] req_tag     = '0;
    logic             req_ready;
    logic [31:0]      fmad_rslt   = '0;
    logic [4:0]       fmad_flag   = '0;
    logic             resp_valid;
    logic             resp_ready  = 1'b0;
    logic [31:0]      resp_rslt;
    logic [4:0]       resp_flag;
    logic [TAG_W-1:0] resp_tag;
    logic [4:0]       fflags;
    logic             fflags_clr  = 1'b0;

    always #5 clk = ~clk;

    fmad_resp_queue #(.DEPTH(DEPTH), .LAT(LAT), .TAG_W(TAG_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .req_command (req_command),
        .req_tag     (req_tag),
        .req_ready   (req_ready),
        .fmad_rslt   (fmad_rslt),
        .fmad_flag   (fmad_flag),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_rslt   (resp_rslt),
        .resp_flag   (resp_flag),
        .resp_tag    (resp_tag),
        .fflags      (fflags),
        .fflags_clr  (fflags_clr)
    );

    typedef struct {
        logic [31:0]      rslt;
        logic [4:0]       flag;
        logic [TAG_W-1:0] tag;
        int               vis_cycle;
    } exp_t;

    exp_t        sb[$];
    int          cyc         = 0;
    int          n_vec       = 0;
    int          n_err       = 0;
    logic        model_ready = 1'b1;
    logic [4:0]  model_ff    = '0;
    logic [31:0] slot_rslt [64];
    logic [4:0]  slot_flag [64];
    bit          slot_v    [64];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One cycle of stimulus; also plays the role of fmad, returning each result LAT cycles after issue.
    task automatic step(input logic rst, input logic r, input logic [31:0] cmd,
                        input logic [TAG_W-1:0] tag, input logic [31:0] rs,
                        input logic [4:0] fl, input logic rr, input logic clr);
        int   idx;
        logic rdy;
        exp_t e;
        @(posedge clk);
        #1;
        reset      = rst;
        resp_ready = rr;
        fflags_clr = clr;
        idx        = cyc % 64;
        if (slot_v[idx]) begin
            fmad_rslt   = slot_rslt[idx];
            fmad_flag   = slot_flag[idx];
            slot_v[idx] = 1'b0;
        end else begin
            fmad_rslt = $urandom;
            fmad_flag = 5'($urandom);
        end
        rdy = rst || (sb.size() < DEPTH) || (sb.size() > 0 && sb[0].vis_cycle <= cyc && rr);
        model_ready = rdy;
        req_command = cmd;
        req_tag     = tag;
        if (rst) begin
            sb.delete();
            req = 1'b0;
        end else if (r && cmd == CMD_FMA && !rdy) begin
            req = 1'b0;
        end else begin
            req = r;
            if (r && cmd == CMD_FMA) begin
                e.rslt      = rs;
                e.flag      = fl;
                e.tag       = tag;
                e.vis_cycle = cyc + LAT + 1;
                sb.push_back(e);
                slot_rslt[(cyc + LAT) % 64] = rs;
                slot_flag[(cyc + LAT) % 64] = fl;
                slot_v[(cyc + LAT) % 64]    = 1'b1;
            end
        end
    endtask

    task automatic idle(input logic rr, input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'd0, '0, 32'd0, 5'd0, rr, 1'b0);
    endtask

    // Monitor: compares outputs against the reference queue once per cycle, away from the clock edge.
    always @(negedge clk) begin
        logic exp_v;
        logic pop;
        exp_t e;
        exp_v = !reset && sb.size() > 0 && sb[0].vis_cycle <= cyc;
        check("resp_valid", resp_valid, exp_v);
        check("req_ready", req_ready, model_ready);
        pop = exp_v && resp_ready;
        if (pop) begin
            e = sb.pop_front();
            check("resp_rslt", resp_rslt, e.rslt);
            check("resp_flag", resp_flag, e.flag);
            check("resp_tag", resp_tag, e.tag);
        end
`ifdef FMAD_RESP_STICKY_EN
        check("fflags", fflags, model_ff);
        if (reset)           model_ff = '0;
        else if (fflags_clr) model_ff = pop ? e.flag : 5'd0;
        else if (pop)        model_ff = model_ff | e.flag;
`else
        check("fflags", fflags, 5'd0);
`endif
    end

    initial begin
        logic [4:0] exp_ff;

        step(1'b1, 1'b0, 32'd0, '0, 32'd0, 5'd0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 32'd0, '0, 32'd0, 5'd0, 1'b0, 1'b0);

        // Single op: visible LAT+1 cycles after issue.
        step(1'b0, 1'b1, CMD_FMA, 4'd3, 32'h3f80_0000, 5'd0, 1'b1, 1'b0);
        idle(1'b1, 5);

        // Dot-accumulate and other commands never enter the queue.
        for (int i = 0; i < 8; i++)
            step(1'b0, 1'b1, CMD_DOT, TAG_W'(i), $urandom, 5'($urandom), 1'b1, 1'b0);
        step(1'b0, 1'b1, 32'd7, '0, 32'd0, 5'd0, 1'b1, 1'b0);
        idle(1'b1, 3);

        // Backpressure: only DEPTH ops accepted, then drained in order.
        for (int i = 0; i < 6; i++)
            step(1'b0, 1'b1, CMD_FMA, TAG_W'(i), $urandom, 5'($urandom), 1'b0, 1'b0);
        idle(1'b0, 3);
        idle(1'b1, 6);

        // Fill to full, then random traffic including take with simultaneous pop.
        for (int i = 0; i < DEPTH; i++)
            step(1'b0, 1'b1, CMD_FMA, TAG_W'(i + 8), $urandom, 5'($urandom), 1'b0, 1'b0);
        idle(1'b0, 3);
        for (int i = 0; i < 150; i++) begin
            logic [31:0] cmd;
            cmd = ($urandom_range(0, 4) == 0) ? CMD_DOT : CMD_FMA;
            step(1'b0, $urandom_range(0, 3) != 0, cmd, TAG_W'($urandom), $urandom,
                 5'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
        end
        for (int i = 0; i < 50 && sb.size() > 0; i++) idle(1'b1, 1);
        check("drain_timeout", 64'(sb.size()), 64'd0);

        // Reset with ops both in the pipe and queued; stale fmad results must not appear.
        for (int i = 0; i < DEPTH; i++)
            step(1'b0, 1'b1, CMD_FMA, TAG_W'(i), $urandom, 5'($urandom), 1'b0, 1'b0);
        step(1'b1, 1'b0, 32'd0, '0, 32'd0, 5'd0, 1'b0, 1'b0);
        idle(1'b1, 6);

        // Sticky flags: 0x01 then 0x04 accrue, clear alongside a pop of 0x10 keeps only 0x10.
        step(1'b1, 1'b0, 32'd0, '0, 32'd0, 5'd0, 1'b0, 1'b0);
        step(1'b0, 1'b1, CMD_FMA, 4'd1, 32'h1111_1111, 5'h01, 1'b0, 1'b0);
        step(1'b0, 1'b1, CMD_FMA, 4'd2, 32'h2222_2222, 5'h04, 1'b0, 1'b0);
        step(1'b0, 1'b1, CMD_FMA, 4'd3, 32'h3333_3333, 5'h10, 1'b0, 1'b0);
        idle(1'b0, 4);
        idle(1'b1, 1);
        idle(1'b1, 1);
        idle(1'b0, 1);
`ifdef FMAD_RESP_STICKY_EN
        exp_ff = 5'h05;
`else
        exp_ff = 5'h00;
`endif
        check("fflags_accrue", fflags, exp_ff);
        step(1'b0, 1'b0, 32'd0, '0, 32'd0, 5'd0, 1'b1, 1'b1);
        idle(1'b0, 1);
`ifdef FMAD_RESP_STICKY_EN
        exp_ff = 5'h10;
`else
        exp_ff = 5'h00;
`endif
        check("fflags_clear_pop", fflags, exp_ff);
        idle(1'b1, 3);

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
